// File: rtl/fwd_pkg.sv
// Shared types and helpers for the EX-stage forwarding / load-use scoreboard.
// Entry rd is stored at a fixed maximum width so one struct serves every RAW.
package fwd_pkg;

  localparam int FWD_RAW_MAX = 16;
  localparam int FWD_SEL_RF  = 0;

  typedef struct packed {
    logic                   valid;
    logic                   regwrite;
    logic                   is_load;
    logic [FWD_RAW_MAX-1:0] rd;
  } fwd_entry_t;

  function automatic int fwd_selw(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fwd_src_select.sv
// Per-operand producer search: youngest matching stage wins; a load that is
// still too young blocks forwarding and flags a hazard instead.
module fwd_src_select
  import fwd_pkg::*;
#(
  parameter int REG_ADDR_WIDTH   = 5,
  parameter int DEPTH            = 3,
  parameter int LOAD_READY_STAGE = 2,
  parameter int SELW             = fwd_selw(DEPTH)
) (
  input  fwd_entry_t [DEPTH:1]        i_entries,
  input  logic [REG_ADDR_WIDTH-1:0]   i_rs,
  output logic [SELW-1:0]             o_sel,
  output logic                        o_load_hazard
);

  logic [FWD_RAW_MAX-1:0] w_rs;
  logic                   w_found;

  assign w_rs = FWD_RAW_MAX'(i_rs);

  always_comb begin
    o_sel         = SELW'(FWD_SEL_RF);
    o_load_hazard = 1'b0;
    w_found       = 1'b0;
    for (int k = 1; k <= DEPTH; k++) begin
      if (!w_found &&
          i_entries[k].valid &&
          i_entries[k].regwrite &&
          i_entries[k].rd != '0 &&
          i_entries[k].rd == w_rs) begin
        w_found = 1'b1;
        // never fall back to an older producer behind a pending load
        if (i_entries[k].is_load && k < LOAD_READY_STAGE)
          o_load_hazard = 1'b1;
        else
          o_sel = SELW'(k);
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding and load-use hazard unit: shift pipeline of destination tags
// behind EX, per-operand forward select, and the ID/EX stall request.
module fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter int REG_ADDR_WIDTH   = 5,
  parameter int NUM_SRC          = 2,
  parameter int DEPTH            = 3,
  parameter int LOAD_READY_STAGE = 2
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 in_issue_valid,
  input  logic [REG_ADDR_WIDTH-1:0]            in_issue_rd,
  input  logic                                 in_issue_regwrite,
  input  logic                                 in_issue_is_load,
  input  logic [NUM_SRC*REG_ADDR_WIDTH-1:0]    in_src_rs,
  input  logic                                 in_advance,
  input  logic                                 in_flush,
  output logic [NUM_SRC*fwd_selw(DEPTH)-1:0]   out_fwd_sel,
  output logic                                 out_stall,
  output logic [DEPTH-1:0]                     out_valid_mask
);

  localparam int SELW = fwd_selw(DEPTH);

  fwd_entry_t [DEPTH:1] r_entries;
  fwd_entry_t           w_new;
  logic [NUM_SRC-1:0]   w_haz;
  logic                 w_stall;
  logic                 w_insert;

  assign w_stall  = in_issue_valid && !in_flush && (|w_haz);
  assign w_insert = in_issue_valid && !in_flush && !w_stall;
  assign out_stall = w_stall;

  always_comb begin
    w_new = '0;
    if (w_insert) begin
      w_new.valid    = 1'b1;
      w_new.regwrite = in_issue_regwrite;
      w_new.is_load  = in_issue_is_load;
      w_new.rd       = FWD_RAW_MAX'(in_issue_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_entries <= '0;
    end else if (in_advance) begin
      for (int k = DEPTH; k >= 2; k--)
        r_entries[k] <= r_entries[k-1];
      r_entries[1] <= w_new;
    end
  end

  for (genvar k = 1; k <= DEPTH; k++) begin : g_mask
    assign out_valid_mask[k-1] = r_entries[k].valid;
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_src_select #(
      .REG_ADDR_WIDTH   (REG_ADDR_WIDTH),
      .DEPTH            (DEPTH),
      .LOAD_READY_STAGE (LOAD_READY_STAGE),
      .SELW             (SELW)
    ) u_sel (
      .i_entries     (r_entries),
      .i_rs          (in_src_rs[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]),
      .o_sel         (out_fwd_sel[i*SELW +: SELW]),
      .o_load_hazard (w_haz[i])
    );
  end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Bench for fwd_scoreboard: behavioural pipeline model feeds an expectation
// queue; directed scenarios add fixed-value checks on top.
module tb_fwd_scoreboard;

  localparam int RAW = 5;
  localparam int NS  = 2;
  localparam int D   = 3;
  localparam int LRS = 2;
  localparam int SW  = 2;

  typedef struct {
    logic [D-1:0]  mask;
    logic [SW-1:0] sel0;
    logic [SW-1:0] sel1;
    logic          stall;
  } exp_t;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_issue_valid;
  logic [RAW-1:0]     in_issue_rd;
  logic               in_issue_regwrite;
  logic               in_issue_is_load;
  logic [NS*RAW-1:0]  in_src_rs;
  logic               in_advance;
  logic               in_flush;
  logic [NS*SW-1:0]   out_fwd_sel;
  logic               out_stall;
  logic [D-1:0]       out_valid_mask;

  fwd_scoreboard dut (
    .clk               (clk),
    .reset             (reset),
    .in_issue_valid    (in_issue_valid),
    .in_issue_rd       (in_issue_rd),
    .in_issue_regwrite (in_issue_regwrite),
    .in_issue_is_load  (in_issue_is_load),
    .in_src_rs         (in_src_rs),
    .in_advance        (in_advance),
    .in_flush          (in_flush),
    .out_fwd_sel       (out_fwd_sel),
    .out_stall         (out_stall),
    .out_valid_mask    (out_valid_mask)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  exp_t exp_q[$];

  logic           mv  [1:D];
  logic           mrw [1:D];
  logic           mld [1:D];
  logic [RAW-1:0] mrd [1:D];

  logic [D-1:0]  o_mask;
  logic [SW-1:0] o_sel0;
  logic [SW-1:0] o_sel1;
  logic          o_stall;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void msel(input logic [RAW-1:0] rs,
                               output logic [SW-1:0] sel,
                               output logic haz);
    sel = '0;
    haz = 1'b0;
    for (int k = D; k >= 1; k--) begin
      if (mv[k] && mrw[k] && mrd[k] != '0 && mrd[k] == rs) begin
        haz = mld[k] && (k < LRS);
        sel = haz ? SW'(0) : SW'(k);
      end
    end
  endfunction

  task automatic step(input logic rst, input logic v, input logic rw,
                      input logic ld, input logic [RAW-1:0] rd,
                      input logic [RAW-1:0] rs0, input logic [RAW-1:0] rs1,
                      input logic adv, input logic fl);
    exp_t e;
    exp_t g;
    logic h0;
    logic h1;
    @(negedge clk);
    reset             = rst;
    in_issue_valid    = v;
    in_issue_rd       = rd;
    in_issue_regwrite = rw;
    in_issue_is_load  = ld;
    in_src_rs         = {rs1, rs0};
    in_advance        = adv;
    in_flush          = fl;
    #1;
    msel(rs0, e.sel0, h0);
    msel(rs1, e.sel1, h1);
    for (int k = 1; k <= D; k++) e.mask[k-1] = mv[k];
    e.stall = v && !fl && (h0 || h1);
    exp_q.push_back(e);
    o_mask  = out_valid_mask;
    o_sel0  = out_fwd_sel[SW-1:0];
    o_sel1  = out_fwd_sel[2*SW-1:SW];
    o_stall = out_stall;
    g = exp_q.pop_front();
    chk("mask",  32'(o_mask),  32'(g.mask));
    chk("sel0",  32'(o_sel0),  32'(g.sel0));
    chk("sel1",  32'(o_sel1),  32'(g.sel1));
    chk("stall", 32'(o_stall), 32'(g.stall));
    @(posedge clk);
    if (rst) begin
      for (int k = 1; k <= D; k++) mv[k] = 1'b0;
    end else if (adv) begin
      for (int k = D; k >= 2; k--) begin
        mv[k]  = mv[k-1];
        mrw[k] = mrw[k-1];
        mld[k] = mld[k-1];
        mrd[k] = mrd[k-1];
      end
      mv[1]  = v && !fl && !e.stall;
      mrw[1] = rw;
      mld[1] = ld;
      mrd[1] = rd;
    end
  endtask

  task automatic bub(input logic [RAW-1:0] rs0, input logic [RAW-1:0] rs1);
    step(0, 0, 0, 0, 0, rs0, rs1, 1, 0);
  endtask

  initial begin
    for (int k = 1; k <= D; k++) begin
      mv[k] = 0; mrw[k] = 0; mld[k] = 0; mrd[k] = '0;
    end
    reset = 1'b1;
    in_issue_valid = 1'b1; in_issue_rd = 5'd4; in_issue_regwrite = 1'b1;
    in_issue_is_load = 1'b0; in_src_rs = '0;
    in_advance = 1'b1; in_flush = 1'b0;
    @(posedge clk);

    // reset held with a valid issue pending
    step(1, 1, 1, 0, 5'd4, 5'd4, 5'd4, 1, 0);
    chk("rst_mask", 32'(o_mask), 32'b000);
    chk("rst_stall", 32'(o_stall), 32'd0);
    step(0, 1, 1, 0, 5'd4, 5'd4, 5'd0, 1, 0);
    chk("rst_rel_mask", 32'(o_mask), 32'b000);
    bub(0, 0);
    chk("first_issue", 32'(o_mask), 32'b001);

    // ALU chain
    step(0, 1, 1, 0, 5'd5, 5'd5, 5'd0, 1, 0);
    bub(5, 0); chk("alu_k1", 32'(o_sel0), 32'd1);
    bub(5, 0); chk("alu_k2", 32'(o_sel0), 32'd2);
    bub(5, 0); chk("alu_k3", 32'(o_sel0), 32'd3);
    bub(5, 0); chk("alu_rf", 32'(o_sel0), 32'd0);

    // youngest producer wins; x0 never forwarded
    step(0, 1, 1, 0, 5'd7, 5'd0, 5'd0, 1, 0);
    step(0, 1, 1, 0, 5'd7, 5'd0, 5'd0, 1, 0);
    step(0, 1, 1, 0, 5'd0, 5'd0, 5'd7, 1, 0);
    chk("young", 32'(o_sel1), 32'd1);
    bub(0, 7);
    chk("x0_sel", 32'(o_sel0), 32'd0);
    chk("young2", 32'(o_sel1), 32'd2);

    // load-use
    bub(0, 0); bub(0, 0); bub(0, 0);
    step(0, 1, 1, 1, 5'd3, 5'd0, 5'd0, 1, 0);
    step(0, 1, 1, 0, 5'd9, 5'd0, 5'd3, 1, 0);
    chk("lu_stall", 32'(o_stall), 32'd1);
    chk("lu_sel", 32'(o_sel1), 32'd0);
    step(0, 1, 1, 0, 5'd9, 5'd0, 5'd3, 1, 0);
    chk("lu_mask", 32'(o_mask), 32'b010);
    chk("lu_go", 32'(o_stall), 32'd0);
    chk("lu_fwd", 32'(o_sel1), 32'd2);

    // hold, then flush over a pending hazard
    bub(0, 0); bub(0, 0); bub(0, 0);
    step(0, 1, 1, 1, 5'd6, 5'd0, 5'd0, 1, 0);
    for (int c = 0; c < 3; c++) begin
      step(0, 1, 1, 0, 5'd2, 5'd6, 5'd0, 0, 0);
      chk("hold_mask", 32'(o_mask), 32'b001);
      chk("hold_stall", 32'(o_stall), 32'd1);
    end
    step(0, 1, 1, 0, 5'd2, 5'd6, 5'd0, 1, 1);
    chk("fl_stall", 32'(o_stall), 32'd0);
    bub(6, 0);
    chk("fl_mask", 32'(o_mask), 32'b010);
    chk("fl_sel", 32'(o_sel0), 32'd2);

    // reset mid-operation with a stall pending
    step(0, 1, 1, 0, 5'd10, 5'd0, 5'd0, 1, 0);
    step(0, 1, 1, 0, 5'd11, 5'd0, 5'd0, 1, 0);
    step(0, 1, 1, 1, 5'd8, 5'd0, 5'd0, 1, 0);
    step(1, 1, 1, 0, 5'd12, 5'd8, 5'd0, 0, 0);
    chk("mr_mask", 32'(o_mask), 32'b111);
    chk("mr_stall", 32'(o_stall), 32'd1);
    step(0, 1, 1, 0, 5'd12, 5'd8, 5'd0, 1, 0);
    chk("mr_clr", 32'(o_mask), 32'b000);
    chk("mr_nostall", 32'(o_stall), 32'd0);

    // randomised traffic over a small register set
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 59) == 0,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 2) == 0), RAW'($urandom_range(0, 3)),
           RAW'($urandom_range(0, 3)), RAW'($urandom_range(0, 3)),
           $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fwd_scoreboard.md
# fwd_scoreboard

Parametrised forwarding and load-use hazard unit for the execute stage. It keeps a registered shift-pipeline of destination-register tags for the DEPTH stages downstream of EX. Every cycle it selects, for each of NUM_SRC source operands of the instruction in ID/EX, the youngest in-flight producer. It raises a load-use stall when that producer is a load whose data is not yet forwardable. It replaces the fixed two-stage, two-operand combinational forwarding logic and drives the operand multiplexers and the ID/EX stall/bubble control.

## Interface
Parameters:
- REG_ADDR_WIDTH, 5, register index width (RAW)
- NUM_SRC, 2, source operands checked per instruction
- DEPTH, 3, tracked stages after EX; stage 1 = EX/MEM, stage DEPTH = oldest
- LOAD_READY_STAGE, 2, first stage index (1..DEPTH) where load data is forwardable

Derived: SELW = $clog2(DEPTH+1).

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- in_issue_valid  in  1  instruction in ID/EX is valid this cycle
- in_issue_rd  in  RAW  its destination register
- in_issue_regwrite  in  1  it writes the register file
- in_issue_is_load  in  1  it is a load
- in_src_rs  in  NUM_SRC*RAW  its source registers; operand i at [i*RAW +: RAW]
- in_advance  in  1  pipeline moves this cycle (no downstream stall)
- in_flush  in  1  kill the instruction in ID/EX (branch redirect)
- out_fwd_sel  out  NUM_SRC*SELW  per operand: 0 = register file, k = forward from stage k
- out_stall  out  1  load-use hazard; hold IF/ID and ID/EX, insert bubble
- out_valid_mask  out  DEPTH  entry valid bits, bit k-1 = stage k (debug/verification)

## Operation
- Entry k holds {valid, regwrite, is_load, rd}.
- Reset: all entries cleared (valid=0). Outputs are then out_fwd_sel=0, out_stall=0, out_valid_mask=0.
- On a clock edge with in_advance=1:
  - entry k <= entry k-1 for k=2..DEPTH; entry DEPTH is discarded.
  - entry 1 <= the issuing instruction if in_issue_valid && !in_flush && !out_stall; otherwise a bubble (valid=0).
- On a clock edge with in_advance=0: all entries hold, including during flush or stall.
- Match for operand i at stage k: valid && regwrite && rd != 0 && rd == rs_i.
- out_fwd_sel[i] = smallest k that matches, i.e. the youngest producer wins. It is 0 when no stage matches.
- Load hazard for operand i: the youngest match is an is_load entry with k < LOAD_READY_STAGE.
  - In that case out_fwd_sel[i] = 0. An older match is never used in its place.
- out_stall = in_issue_valid && !in_flush && (load hazard on any operand).
- Register x0 (rs == 0) is never forwarded and never stalls.
- Simultaneous in_flush and hazard: flush wins, so stall=0 and a bubble enters stage 1.
- Stall with in_advance=0: stall stays asserted and state holds.
- Reset asserted mid-operation clears all entries on that edge, regardless of advance, flush or issue.

## Timing
- out_fwd_sel, out_stall and out_valid_mask are combinational from registered entries and current inputs. There are no registered outputs.
- An issued instruction becomes visible as stage 1 one cycle after issue with in_advance=1. It then moves one stage per advancing cycle.
- A load-use stall lasts until the load reaches LOAD_READY_STAGE. With defaults and continuous advance this is exactly 1 cycle.
- A producer is forwardable for DEPTH advancing cycles. After that the operand comes from the register file (sel 0).

## Structure
- Package fwd_pkg holds:
  - the entry struct typedef fwd_entry_t
  - the constant FWD_SEL_RF = 0
  - a function computing SELW from DEPTH
- Sub-module fwd_src_select: one instance per operand, generated NUM_SRC times.
  - Takes the entry array and one rs.
  - Returns sel and load_hazard via a priority scan from stage 1 to DEPTH.
- Top level contains the entry shift register, the bubble/insert logic and the stall OR-reduction.

## Test plan
All scenarios use defaults (RAW=5, NUM_SRC=2, DEPTH=3, LOAD_READY_STAGE=2).
- Reset:
  - Stimulus: reset high 2 cycles with in_issue_valid=1, rd=4.
  - Response: out_valid_mask=000, out_fwd_sel all 0, out_stall=0.
  - After release, the first issue appears as mask=001.
- ALU chain:
  - Stimulus: issue rd=5 regwrite, then bubbles, continuous advance, rs0=5.
  - Response: sel[0] reads 1, 2, 3, then 0 on the following cycles.
- Youngest wins:
  - Stimulus: rd=7 in stage 2 and rd=7 in stage 1, rs1=7.
  - Response: sel[1]=1. With rd=0 regwrite in stage 1 and rs0=0, sel[0]=0.
- Load-use:
  - Stimulus: issue load rd=3; next cycle issue valid with rs1=3.
  - Response: out_stall=1, sel[1]=0. After one advance the load is in stage 2 and stage 1 holds a bubble (mask=010); then stall=0, sel[1]=2.
- Hold and flush:
  - Stimulus: in_advance=0 for 3 cycles.
  - Response: mask and sels unchanged.
  - Stimulus: in_flush=1 with a pending load hazard.
  - Response: stall=0, and stage 1 receives a bubble on the next advance.
- Mid-operation reset:
  - Stimulus: mask=111 with a stall pending, then reset asserted.
  - Response: next cycle mask=000, stall=0.
